// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encoding and timing helpers for the RSA decrypt block
package rsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQR  = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SQR  = ST_SQR,
    MUL  = ST_MUL,
    DONE = ST_DONE
  } state_t;

  function automatic int op_cycles(input int width);
    return 2 * width + 2;
  endfunction

  // Start-to-finish latency; depends on the exponent's popcount by design.
  function automatic int sqm_latency(input int width, input logic [63:0] d, input logic [63:0] n);
    int ones;
    ones = 0;
    for (int b = 0; b < 2 * width; b++) begin
      if (d[b]) ones++;
    end
    if (n == 64'd0) return 2;
    return 2 + (2 * width + ones) * op_cycles(width);
  endfunction

endpackage

// File: rtl/rsa_decrypt_sqm_mod_mult_serial.sv
// rtl/rsa_decrypt_sqm_mod_mult_serial.sv - bit-serial interleaved modular multiplier, one bit of b per cycle
module mod_mult_serial #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] out,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  n_r;
  logic [CW-1:0] cnt;
  logic          run;
  logic [W:0]    dbl;
  logic [W:0]    dbl_red;
  logic [W:0]    sum;
  logic [W:0]    sum_red;

  // One extra bit keeps 2*acc and acc+a exact even when n is all ones.
  always_comb begin
    dbl     = {out, 1'b0};
    dbl_red = (dbl >= {1'b0, n_r}) ? dbl - {1'b0, n_r} : dbl;
    sum     = dbl_red + (b_r[W-1] ? {1'b0, a_r} : '0);
    sum_red = (sum >= {1'b0, n_r}) ? sum - {1'b0, n_r} : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      n_r  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r <= a;
        b_r <= b;
        n_r <= n;
        out <= '0;
        cnt <= CW'(W);
        run <= 1'b1;
      end else if (run) begin
        out <= sum_red[W-1:0];
        b_r <= {b_r[W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_decrypt_sqm.sv
// rtl/rsa_decrypt_sqm.sv - left-to-right square-and-multiply m = c^d mod n with data-dependent timing
module rsa_decrypt_sqm
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   c,
  input  logic [2*WIDTH-1:0]   d,
  input  logic [2*WIDTH-1:0]   n,
  output logic [2*WIDTH-1:0]   m,
  output logic                 finish,
  output logic                 busy
);

  localparam int W2 = 2 * WIDTH;
  localparam int IW = $clog2(W2);

  state_t          state;
  logic [W2-1:0]   c_r;
  logic [W2-1:0]   d_r;
  logic [W2-1:0]   n_r;
  logic [W2-1:0]   r;
  logic [IW-1:0]   i;
  logic            mul_start;
  logic [W2-1:0]   mul_b;
  logic [W2-1:0]   mul_out;
  logic            mul_done;

  // Operands are sampled one edge after issue, when r already holds the latest result.
  assign mul_b = (state == MUL) ? c_r : r;

  mod_mult_serial #(.W(W2)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (r),
    .b     (mul_b),
    .n     (n_r),
    .out   (mul_out),
    .done  (mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c_r       <= '0;
      d_r       <= '0;
      n_r       <= '0;
      r         <= '0;
      i         <= '0;
      mul_start <= 1'b0;
      m         <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      finish    <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            c_r  <= c;
            d_r  <= d;
            n_r  <= n;
            busy <= 1'b1;
            i    <= IW'(W2 - 1);
            if (n == '0) begin
              r     <= '0;
              state <= DONE;
            end else begin
              r         <= (n == W2'(1)) ? '0 : W2'(1);
              mul_start <= 1'b1;
              state     <= SQR;
            end
          end
        end
        SQR: begin
          if (mul_done) begin
            r <= mul_out;
            if (d_r[i]) begin
              mul_start <= 1'b1;
              state     <= MUL;
            end else if (i == '0) begin
              state <= DONE;
            end else begin
              i         <= i - IW'(1);
              mul_start <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            r <= mul_out;
            if (i == '0) begin
              state <= DONE;
            end else begin
              i         <= i - IW'(1);
              mul_start <= 1'b1;
              state     <= SQR;
            end
          end
        end
        DONE: begin
          m      <= r;
          finish <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_sqm.sv
// tb/tb_rsa_decrypt_sqm.sv - randomized and directed bench for rsa_decrypt_sqm against an arithmetic model
module tb_rsa_decrypt_sqm;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] c;
  logic [15:0] d;
  logic [15:0] n;
  logic [15:0] m;
  logic        finish;
  logic        busy;

  int checks;
  int failures;

  rsa_decrypt_sqm #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .c      (c),
    .d      (d),
    .n      (n),
    .m      (m),
    .finish (finish),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned ref_modexp(input longint unsigned cc, input logic [15:0] dd,
                                                 input longint unsigned nn);
    longint unsigned r;
    if (nn == 0) return 0;
    r = 1 % nn;
    for (int b = 15; b >= 0; b--) begin
      r = (r * r) % nn;
      if (dd[b]) r = (r * cc) % nn;
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [15:0] dd, input logic [15:0] nn);
    if (nn == 16'd0) return 2;
    return 2 + (16 + $countones(dd)) * 18;
  endfunction

  task automatic do_run(input logic [15:0] cc, input logic [15:0] dd, input logic [15:0] nn,
                        input bit mid, output int lat, output logic [15:0] res,
                        output logic busy_gap, output bit busy_ok);
    int k;
    @(negedge clk);
    busy_gap = busy;
    c = cc; d = dd; n = nn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (!finish && k < 2000) begin
      if (!busy) busy_ok = 1'b0;
      if (mid && k == 50) begin
        start = 1'b1; c = 16'd7; d = 16'hffff; n = 16'd11;
      end
      if (mid && k == 51) start = 1'b0;
      @(negedge clk);
      k++;
    end
    if (!busy) busy_ok = 1'b0;
    lat = k + 1;
    res = m;
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] cc, input logic [15:0] dd,
                               input logic [15:0] nn, input bit mid);
    int lat;
    logic [15:0] res;
    logic gap;
    bit bok;
    do_run(cc, dd, nn, mid, lat, res, gap, bok);
    chk({tag, "_m"}, res, ref_modexp(cc, dd, nn));
    chk({tag, "_lat"}, lat, ref_latency(dd, nn));
    chk({tag, "_busy"}, bok, 1);
  endtask

  initial begin
    int lat;
    int fcnt;
    logic [15:0] res;
    logic gap;
    bit bok;
    logic [15:0] rn, rc, rd;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    c = '0; d = '0; n = '0;
    repeat (3) @(negedge clk);
    chk("reset_m", m, 0);
    chk("reset_finish", finish, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    run_and_check("rsa_2753", 16'd2790, 16'd2753, 16'd3233, 1'b0);
    run_and_check("d_zero", 16'd1234, 16'd0, 16'd3233, 1'b0);
    run_and_check("n_one", 16'd0, 16'd0, 16'd1, 1'b0);
    run_and_check("n_zero", 16'd5, 16'd77, 16'd0, 1'b0);

    run_and_check("mid_start", 16'd123, 16'd1, 16'd3233, 1'b1);
    fcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (finish) fcnt++;
    end
    chk("mid_start_one_finish", 1 + fcnt, 1);
    chk("mid_start_m_held", m, 123);

    @(negedge clk);
    c = 16'd2790; d = 16'd2753; n = 16'd3233; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m", m, 0);
    chk("rst_finish", finish, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fcnt = 0;
    repeat (450) begin
      @(negedge clk);
      if (finish) fcnt++;
    end
    chk("rst_no_finish", fcnt, 0);
    run_and_check("after_rst", 16'd2790, 16'd2753, 16'd3233, 1'b0);

    run_and_check("wide_carry", 16'd65534, 16'd65535, 16'd65535, 1'b0);
    do_run(16'd4321, 16'd300, 16'd60001, 1'b0, lat, res, gap, bok);
    chk("b2b_gap_busy", gap, 0);
    chk("b2b_m", res, ref_modexp(4321, 16'd300, 60001));
    chk("b2b_lat", lat, ref_latency(16'd300, 16'd60001));
    chk("b2b_busy_back", bok, 1);

    for (int t = 0; t < 8; t++) begin
      rn = 16'($urandom_range(65535, 2));
      rc = 16'($urandom % rn);
      rd = 16'($urandom_range(65535, 0));
      run_and_check($sformatf("rand%0d", t), rc, rd, rn, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
